instr_fetch_unit: RTL

Sequential instruction fetch front-end that produces the 32-bit instrWord consumed by ControlPath. It is the producer end of that interface.
- Holds the PC and issues word reads to instruction memory over a req/ready + rvalid handshake.
- Buffers returned words in a 2-entry FIFO and presents them to decode with valid/stall flow control.
- Redirects on taken branches.

---
 rtl/instr_fetch_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential instruction-fetch front end. It holds the PC, issues one word
// read at a time to instruction memory (req/ready + rvalid), buffers the
// returned words in a 2-entry FIFO, and presents the head entry to decode
// with valid/stall flow control. A taken branch flushes the buffer and
// redirects the PC. If a read is still in flight when the branch arrives,
// its response is marked to be dropped.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   imem_req        : read request (only in FETCH with buffer space)
//   imem_addr       : word address of the request, bits[1:0] always 0
//   imem_ready      : memory accepts the request this cycle
//   imem_rvalid     : read data valid, one per accepted request
//   imem_rdata      : returned instruction word
//   branch_taken    : redirect fetch this cycle
//   branch_target   : redirect PC, low two bits forced to 0
//   stall           : decode cannot take the head instruction this cycle
//   instrWord       : head instruction, 32'h0 (nop) when not valid
//   instr_valid     : buffer head is valid
//   instr_pc        : PC of instrWord, 0 when not valid
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] instrWord,
    output logic        instr_valid,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    logic [31:0] buf_word_q [BUF_DEPTH];
    logic [31:0] buf_pc_q   [BUF_DEPTH];

    logic head_valid;
    logic not_full;
    logic handshake;
    logic push;
    logic pop;

    assign head_valid = (count_q != 2'd0);
    assign not_full   = (count_q < 2'd2);
    assign handshake  = (state_q == S_FETCH) && not_full && imem_ready;

    // A branch takes priority: it suppresses both the pop and any push.
    assign pop  = head_valid && !stall && !branch_taken;
    assign push = (state_q == S_WAIT) && imem_rvalid && !drop_q && !branch_taken;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case (state_q)
            S_FETCH: begin
                if (!not_full) begin
                    state_d = S_HOLD;
                end else if (imem_ready) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        // Response to a request issued before a redirect.
                        drop_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        pc_d    = req_pc_q + 32'd4;
                        state_d = (count_d < 2'd2) ? S_FETCH : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (count_d < 2'd2) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (branch_taken) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            pc_d     = branch_target & ~32'h3;
            if (state_q == S_WAIT && !imem_rvalid) begin
                // Old read still in flight: drop its response when it lands.
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else if (state_q == S_WAIT) begin
                drop_d  = 1'b0;
                state_d = S_FETCH;
            end else if (handshake) begin
                // The request accepted this cycle is for the old path.
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Buffer storage needs no reset: count_q qualifies every read.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == 1'(gi))) begin
                    buf_word_q[gi] <= imem_rdata;
                    buf_pc_q[gi]   <= req_pc_q;
                end
            end
        end
    endgenerate

    // Outputs are forced to their idle values while reset is asserted.
    assign imem_req    = (state_q == S_FETCH) && not_full && !reset;
    assign imem_addr   = reset ? RESET_PC : pc_q;
    assign instr_valid = head_valid && !reset;
    assign instrWord   = instr_valid ? buf_word_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q] : 32'h0;

endmodule
